// File: rtl/bus1_arbiter_if.sv
// Requester-side handshake bundle for bus1_arbiter: two valid/ready request ports
// with their single-pulse completion returns. master = requester side, slave = arbiter side.
interface bus1_arbiter_if #(
  parameter int CTR1_W = 3,
  parameter int ADDR_W = 19
);
  logic              r0_valid;
  logic              r0_ready;
  logic [CTR1_W-1:0] r0_cmd;
  logic [ADDR_W-1:0] r0_addr;
  logic [31:0]       r0_wdata;
  logic              r0_rvalid;
  logic [31:0]       r0_rdata;
  logic              r0_err;

  logic              r1_valid;
  logic              r1_ready;
  logic [CTR1_W-1:0] r1_cmd;
  logic [ADDR_W-1:0] r1_addr;
  logic [31:0]       r1_wdata;
  logic              r1_rvalid;
  logic [31:0]       r1_rdata;
  logic              r1_err;

  modport master (
    output r0_valid, r0_cmd, r0_addr, r0_wdata,
    input  r0_ready, r0_rvalid, r0_rdata, r0_err,
    output r1_valid, r1_cmd, r1_addr, r1_wdata,
    input  r1_ready, r1_rvalid, r1_rdata, r1_err
  );

  modport slave (
    input  r0_valid, r0_cmd, r0_addr, r0_wdata,
    output r0_ready, r0_rvalid, r0_rdata, r0_err,
    input  r1_valid, r1_cmd, r1_addr, r1_wdata,
    output r1_ready, r1_rvalid, r1_rdata, r1_err
  );
endinterface

// File: rtl/bus1_arbiter.sv
// Round-robin two-requester arbiter and sequencer, the sole master of bus1 (A1/D1/C1).
// Optional WAIT watchdog enabled by defining BUS1_ARB_TIMEOUT_EN.
module bus1_arbiter #(
  parameter int ADDR1_W = 15,
  parameter int OFFSET_W = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int CTR1_W = 3,
  parameter logic [CTR1_W-1:0] C1_RESPONSE = 3'd7
`ifdef BUS1_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic               CLK,
  input  logic               RESET,
  bus1_arbiter_if.slave      req,
  output logic               owner,
  output logic               busy,
  inout  wire [ADDR1_W-1:0]  A1,
  inout  wire [DATA_W-1:0]   D1,
  inout  wire [CTR1_W-1:0]   C1
);

  localparam logic [CTR1_W-1:0] CMD_NOP     = 3'd0;
  localparam logic [CTR1_W-1:0] CMD_READ8   = 3'd1;
  localparam logic [CTR1_W-1:0] CMD_READ32  = 3'd3;
  localparam logic [CTR1_W-1:0] CMD_INVAL   = 3'd4;
  localparam logic [CTR1_W-1:0] CMD_WRITE32 = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_OFFS, S_TURN, S_WAIT, S_BEAT2, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CTR1_W-1:0]  cmd_q, cmd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               owner_q, owner_d;
  logic               lastGrant_q, lastGrant_d;
`ifdef BUS1_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  logic anyValid, grantIdx, isWrite;
  logic [ADDR1_W-1:0] a1Val;
  logic [DATA_W-1:0]  d1Val;
  logic driveA, driveD;

  // On a tie the requester that did not win last time goes first.
  assign anyValid = req.r0_valid | req.r1_valid;
  assign grantIdx = (req.r0_valid & req.r1_valid) ? ~lastGrant_q : req.r1_valid;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
`ifdef BUS1_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
`ifdef BUS1_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
`ifdef BUS1_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (anyValid) begin
          cmd_d       = grantIdx ? req.r1_cmd   : req.r0_cmd;
          addr_d      = grantIdx ? req.r1_addr  : req.r0_addr;
          wdata_d     = grantIdx ? req.r1_wdata : req.r0_wdata;
          owner_d     = grantIdx;
          lastGrant_d = grantIdx;
          rdata_d     = '0;
`ifdef BUS1_ARB_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = (cmd_d == CMD_NOP) ? S_DONE : S_CMD;
        end
      end
      S_CMD:  state_d = S_OFFS;
      S_OFFS: state_d = S_TURN;
      S_TURN: begin
        state_d = S_WAIT;
`ifdef BUS1_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (C1 == C1_RESPONSE) begin
          if (cmd_q == CMD_READ8) begin
            rdata_d[7:0] = D1[7:0];
          end else if (cmd_q != CMD_NOP && cmd_q < CMD_INVAL) begin
            rdata_d[15:0] = D1;
          end
          state_d = (cmd_q == CMD_READ32) ? S_BEAT2 : S_DONE;
`ifdef BUS1_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_BEAT2: begin
        rdata_d[31:16] = D1;
        state_d        = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only CMD and OFFS drive the bus; every other state leaves it to the cache.
  assign isWrite = (cmd_q > CMD_INVAL);
  assign driveA  = (state_q == S_CMD) || (state_q == S_OFFS);
  assign driveD  = ((state_q == S_CMD) && isWrite) ||
                   ((state_q == S_OFFS) && (cmd_q == CMD_WRITE32));
  assign a1Val   = (state_q == S_CMD) ? addr_q[ADDR_W-1:OFFSET_W]
                                      : {{(ADDR1_W-OFFSET_W){1'b0}}, addr_q[OFFSET_W-1:0]};
  assign d1Val   = (state_q == S_CMD) ? wdata_q[15:0] : wdata_q[31:16];

  assign A1 = driveA ? a1Val : {ADDR1_W{1'bz}};
  assign C1 = driveA ? cmd_q : {CTR1_W{1'bz}};
  assign D1 = driveD ? d1Val : {DATA_W{1'bz}};

  assign owner = owner_q;
  assign busy  = (state_q != S_IDLE);

  assign req.r0_ready  = !RESET && (state_q == S_IDLE) && anyValid && !grantIdx;
  assign req.r1_ready  = !RESET && (state_q == S_IDLE) && anyValid &&  grantIdx;
  assign req.r0_rvalid = (state_q == S_DONE) && !owner_q;
  assign req.r1_rvalid = (state_q == S_DONE) &&  owner_q;
  assign req.r0_rdata  = owner_q ? 32'd0 : rdata_q;
  assign req.r1_rdata  = owner_q ? rdata_q : 32'd0;
`ifdef BUS1_ARB_TIMEOUT_EN
  assign req.r0_err    = req.r0_rvalid & err_q;
  assign req.r1_err    = req.r1_rvalid & err_q;
`else
  assign req.r0_err    = 1'b0;
  assign req.r1_err    = 1'b0;
`endif

endmodule
